// File: rtl/act_lut_addr_pipe_if.sv
// Beat-level bus of the activation-LUT address pipeline: input beat, output beat,
// and the valid/ready pair for each side.
interface act_lut_addr_pipe_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EQ_WIDTH   = 4,
  parameter int ADDR_WIDTH = 5
) ();
  logic                         i_valid;
  logic                         o_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] i_round_dat;
  logic [EQ_WIDTH-1:0]          i_q_encode;
  logic [EQ_WIDTH-1:0]          c_q_encode;
  logic                         o_valid;
  logic                         i_ready;
  logic [NUM_CH*ADDR_WIDTH-1:0] o_act_lut_addr;
  logic [2*NUM_CH-1:0]          o_sat;

  modport slave (
    input  i_valid, i_round_dat, i_q_encode, c_q_encode, i_ready,
    output o_ready, o_valid, o_act_lut_addr, o_sat
  );

  modport master (
    output i_valid, i_round_dat, i_q_encode, c_q_encode, i_ready,
    input  o_ready, o_valid, o_act_lut_addr, o_sat
  );
endinterface

// File: rtl/act_lut_addr_pipe.sv
// Two-stage multi-lane activation-LUT address generator with valid/ready flow control.
// Optional saturation statistics counters are built when ACT_LUT_STATS_EN is defined.
module act_lut_addr_pipe #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int EQ_WIDTH   = 4,
  parameter int SEG_BITS   = 3,
  parameter int MAX_SHIFT  = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  act_lut_addr_pipe_if.slave        bus,
  input  logic                      i_stat_clr,
  output logic [15:0]               o_ovf_cnt,
  output logic [15:0]               o_unf_cnt
);

  localparam int SW   = $clog2(MAX_SHIFT + 1);
  localparam int YW   = DATA_WIDTH + MAX_SHIFT;
  localparam int SEGW = SEG_BITS + 1;
  localparam int OVA  = 2 ** (SEG_BITS + 1);
  localparam int LSBW = DATA_WIDTH - 1 - SEG_BITS;

  logic                       w_s2_adv;
  logic [EQ_WIDTH-1:0]        w_qdiff;
  logic [SW-1:0]              w_shift;
  logic [NUM_CH*SEGW-1:0]     w_seg;
  logic [NUM_CH-1:0]          w_ovf;
  logic [NUM_CH-1:0]          w_unf;
  logic [NUM_CH*ADDR_WIDTH-1:0] w_addr_next;
  logic [2*NUM_CH-1:0]        w_sat_next;

  logic                       r_s1_valid;
  logic [NUM_CH*SEGW-1:0]     r_s1_seg;
  logic [NUM_CH-1:0]          r_s1_ovf;
  logic [NUM_CH-1:0]          r_s1_unf;
  logic                       r_o_valid;
  logic [NUM_CH*ADDR_WIDTH-1:0] r_addr;
  logic [2*NUM_CH-1:0]        r_sat;

  assign w_s2_adv    = !r_o_valid | bus.i_ready;
  assign bus.o_ready = !r_s1_valid | w_s2_adv;

  // Shift only when the LUT format has more fraction bits; a wrapped difference means none.
  always_comb begin
    w_qdiff = bus.c_q_encode - bus.i_q_encode;
    w_shift = '0;
    if (bus.i_q_encode < bus.c_q_encode) begin
      if (32'(w_qdiff) > 32'(MAX_SHIFT)) w_shift = SW'(MAX_SHIFT);
      else                               w_shift = SW'(w_qdiff);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] w_x;
      logic                  w_neg;
      logic [YW-1:0]         w_x_ext;
      logic [YW-1:0]         w_y;
      logic [LSBW-1:0]       w_lsb_unused;

      assign w_x          = bus.i_round_dat[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_neg        = w_x[DATA_WIDTH-1];
      assign w_x_ext      = {{MAX_SHIFT{w_neg}}, w_x};
      assign w_y          = w_x_ext << w_shift;
      assign w_lsb_unused = w_y[LSBW-1:0];
      // The shifted value fits in W bits only if every bit above the W-bit sign matches it.
      assign w_ovf[gi]    = !w_neg & (|w_y[YW-1:DATA_WIDTH-1]);
      assign w_unf[gi]    = w_neg & !(&w_y[YW-1:DATA_WIDTH-1]);
      assign w_seg[gi*SEGW +: SEGW] = {w_y[DATA_WIDTH-1], w_y[DATA_WIDTH-2 -: SEG_BITS]};

      assign w_addr_next[gi*ADDR_WIDTH +: ADDR_WIDTH] =
          r_s1_ovf[gi] ? ADDR_WIDTH'(OVA) :
          r_s1_unf[gi] ? ADDR_WIDTH'(OVA + 1) :
                         ADDR_WIDTH'(r_s1_seg[gi*SEGW +: SEGW]);
      assign w_sat_next[2*gi +: 2] = {r_s1_unf[gi], r_s1_ovf[gi]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_seg   <= '0;
      r_s1_ovf   <= '0;
      r_s1_unf   <= '0;
    end else if (bus.o_ready) begin
      r_s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_s1_seg <= w_seg;
        r_s1_ovf <= w_ovf;
        r_s1_unf <= w_unf;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_o_valid <= 1'b0;
      r_addr    <= '0;
      r_sat     <= '0;
    end else if (w_s2_adv) begin
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_addr <= w_addr_next;
        r_sat  <= w_sat_next;
      end
    end
  end

  assign bus.o_valid        = r_o_valid;
  assign bus.o_act_lut_addr = r_addr;
  assign bus.o_sat          = r_sat;

`ifdef ACT_LUT_STATS_EN
  logic        w_out_fire;
  logic [16:0] w_ovf_sum;
  logic [16:0] w_unf_sum;
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_unf_cnt;

  function automatic logic [16:0] f_popcnt(input logic [2*NUM_CH-1:0] v, input int b);
    logic [16:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + 17'(v[2*i+b]);
    return c;
  endfunction

  assign w_out_fire = r_o_valid & bus.i_ready;
  assign w_ovf_sum  = {1'b0, r_ovf_cnt} + f_popcnt(r_sat, 0);
  assign w_unf_sum  = {1'b0, r_unf_cnt} + f_popcnt(r_sat, 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (i_stat_clr) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (w_out_fire) begin
      r_ovf_cnt <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
      r_unf_cnt <= w_unf_sum[16] ? 16'hFFFF : w_unf_sum[15:0];
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
  assign o_unf_cnt = r_unf_cnt;
`else
  logic w_stat_clr_unused;
  assign w_stat_clr_unused = i_stat_clr;
  assign o_ovf_cnt = '0;
  assign o_unf_cnt = '0;
`endif

endmodule

// File: tb/tb_act_lut_addr_pipe.sv
// Scoreboard bench for act_lut_addr_pipe: expected beats are queued on accept
// and compared against every valid output cycle, including stalled ones.
module tb_act_lut_addr_pipe;
  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int EQW    = 4;
  localparam int SEG    = 3;
  localparam int MAXS   = 4;
  localparam int AW     = 5;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stat_clr = 1'b0;
  logic [15:0] o_ovf_cnt;
  logic [15:0] o_unf_cnt;

  act_lut_addr_pipe_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(W), .EQ_WIDTH(EQW), .ADDR_WIDTH(AW)) u_if ();

  act_lut_addr_pipe #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(W), .EQ_WIDTH(EQW),
    .SEG_BITS(SEG), .MAX_SHIFT(MAXS), .ADDR_WIDTH(AW)
  ) u_dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .bus        (u_if.slave),
    .i_stat_clr (i_stat_clr),
    .o_ovf_cnt  (o_ovf_cnt),
    .o_unf_cnt  (o_unf_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NUM_CH*AW-1:0] addr;
    logic [2*NUM_CH-1:0]  sat;
    int                   acc;
    bit                   lat;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_rdy_low = 0;
  int   n_out = 0;
  int   exp_ovf = 0;
  int   exp_unf = 0;
  bit   started = 0;
  bit   lat_flag = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [NUM_CH*W-1:0] d, input logic [EQW-1:0] iq,
                                 input logic [EQW-1:0] cq);
    exp_t e;
    int s, x, y, a;
    bit ov, un;
    s = 0;
    if (iq < cq) begin
      s = int'(cq) - int'(iq);
      if (s > MAXS) s = MAXS;
    end
    e.addr = '0;
    e.sat  = '0;
    e.acc  = 0;
    e.lat  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      x  = $signed(d[k*W +: W]);
      y  = x * (1 << s);
      ov = (x >= 0) && (y > (1 << (W-1)) - 1);
      un = (x < 0) && (y < -(1 << (W-1)));
      if (ov)      a = 1 << (SEG+1);
      else if (un) a = (1 << (SEG+1)) + 1;
      else         a = (y >>> (W-1-SEG)) & ((1 << (SEG+1)) - 1);
      e.addr[k*AW +: AW] = AW'(a);
      e.sat[2*k]         = ov;
      e.sat[2*k+1]       = un;
    end
    return e;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin : mon
    exp_t e;
    if (i_rst_n && started) begin
      chk("o_ready", {31'd0, u_if.o_ready},
          (sb.size() == 2 && !u_if.i_ready) ? 32'd0 : 32'd1);
      if (!u_if.o_ready) n_rdy_low++;
      if (u_if.o_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          chk("addr", 32'(u_if.o_act_lut_addr), 32'(sb[0].addr));
          chk("sat", 32'(u_if.o_sat), 32'(sb[0].sat));
          if (sb[0].lat) begin
            chk("latency", cyc - sb[0].acc, 2);
            sb[0].lat = 0;
          end
          if (u_if.i_ready) begin
            e = sb.pop_front();
            n_out++;
            $display("out beat %0d addr=%h sat=%h", n_out, u_if.o_act_lut_addr, u_if.o_sat);
`ifdef ACT_LUT_STATS_EN
            for (int k = 0; k < NUM_CH; k++) begin
              exp_ovf += int'(e.sat[2*k]);
              exp_unf += int'(e.sat[2*k+1]);
            end
            if (exp_ovf > 65535) exp_ovf = 65535;
            if (exp_unf > 65535) exp_unf = 65535;
`endif
          end
        end
      end
      if (u_if.i_valid && u_if.o_ready) begin
        e = model(u_if.i_round_dat, u_if.i_q_encode, u_if.c_q_encode);
        e.acc = cyc;
        e.lat = lat_flag;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [NUM_CH*W-1:0] d, input logic [EQW-1:0] iq,
                      input logic [EQW-1:0] cq);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    u_if.i_valid     = 1'b1;
    u_if.i_round_dat = d;
    u_if.i_q_encode  = iq;
    u_if.c_q_encode  = cq;
    while (!acc) begin
      @(negedge i_clk);
      acc = u_if.o_ready;
      @(posedge i_clk);
      #1;
      t++;
      if (!acc && t > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        acc = 1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    u_if.i_valid = 1'b0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge i_clk);
      t++;
    end
    chk("drain", sb.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  logic [W-1:0]   tx [9] = '{8'h1F, 8'h20, 8'hDF, 8'hE0, 8'h07, 8'h08, 8'hF8, 8'hF7, 8'h7F};
  logic [EQW-1:0] tiq[9] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
  logic [EQW-1:0] tcq[9] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd9, 4'd9, 4'd9, 4'd9, 4'd3};

  initial begin
    #200000;
    $display("FAIL watchdog sb=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    u_if.i_valid     = 1'b0;
    u_if.i_round_dat = '0;
    u_if.i_q_encode  = '0;
    u_if.c_q_encode  = '0;
    u_if.i_ready     = 1'b1;
    i_rst_n          = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_o_valid", {31'd0, u_if.o_valid}, 32'd0);
    chk("rst_addr", 32'(u_if.o_act_lut_addr), 32'd0);
    chk("rst_sat", 32'(u_if.o_sat), 32'd0);
    chk("rst_o_ready", {31'd0, u_if.o_ready}, 32'd1);
    chk("rst_ovf_cnt", 32'(o_ovf_cnt), 32'd0);
    chk("rst_unf_cnt", 32'(o_unf_cnt), 32'd0);
    i_rst_n = 1'b1;
    started = 1;
    @(posedge i_clk);
    #1;

    // equal Q formats, latency checked
    lat_flag = 1;
    send({8'h11, 8'h22, 8'h33, 8'h5A}, 4'd4, 4'd4);
    lat_flag = 0;
    drain();

    // boundary table, back-to-back
    lat_flag = 1;
    for (int i = 0; i < 9; i++) begin
      r = $urandom();
      send({r[31:8], tx[i]}, tiq[i], tcq[i]);
    end
    lat_flag = 0;
    drain();

    // distinct lanes
    send({8'hF0, 8'h10, 8'h80, 8'h7F}, 4'd7, 4'd3);
    drain();

    // stream with downstream stall
    n_rdy_low = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom(), 4'd2, 4'd4);
        u_if.i_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge i_clk);
        #1 u_if.i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 u_if.i_ready = 1'b1;
      end
    join
    drain();
    chk("stall_ready_low", {31'd0, n_rdy_low > 0}, 32'd1);

    // random formats with random backpressure
    fork
      begin
        for (int i = 0; i < 20; i++) send($urandom(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        u_if.i_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(posedge i_clk);
          #1 u_if.i_ready = 1'($urandom_range(0, 1));
        end
        u_if.i_ready = 1'b1;
      end
    join
    u_if.i_ready = 1'b1;
    drain();

    // reset mid-stream
    send($urandom(), 4'd1, 4'd3);
    send($urandom(), 4'd1, 4'd3);
    #2;
    chk("pre_rst_valid", {31'd0, u_if.o_valid}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, u_if.o_valid}, 32'd0);
    chk("mid_rst_addr", 32'(u_if.o_act_lut_addr), 32'd0);
    u_if.i_valid = 1'b0;
    sb.delete();
    exp_ovf = 0;
    exp_unf = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    lat_flag = 1;
    send({8'h40, 8'hC0, 8'h3F, 8'h5A}, 4'd3, 4'd4);
    lat_flag = 0;
    drain();

    // statistics: 3 overflow lanes, then one underflow beat, then clear
    send({8'h05, 8'h20, 8'h20, 8'h20}, 4'd2, 4'd4);
    drain();
    chk("ovf_cnt", 32'(o_ovf_cnt), 32'(exp_ovf));
    chk("unf_cnt", 32'(o_unf_cnt), 32'(exp_unf));
    send({8'h05, 8'hDF, 8'h20, 8'h20}, 4'd2, 4'd4);
    drain();
    chk("ovf_cnt2", 32'(o_ovf_cnt), 32'(exp_ovf));
    chk("unf_cnt2", 32'(o_unf_cnt), 32'(exp_unf));
    i_stat_clr = 1'b1;
    @(posedge i_clk);
    #1 i_stat_clr = 1'b0;
    exp_ovf = 0;
    exp_unf = 0;
    chk("clr_ovf_cnt", 32'(o_ovf_cnt), 32'(exp_ovf));
    chk("clr_unf_cnt", 32'(o_unf_cnt), 32'(exp_unf));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
